// File: rtl/seq_pkg.sv
// seq_pkg: types and constants shared by the serial sequence datapath.
//   seq_state_e  - transmitter FSM state encoding (2-bit)
//   DEF_*        - default geometry of the pattern transmitter
//   PAT_1011     - reference pattern, also used by the detector benches
package seq_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_REP_W   = 4;
  localparam int unsigned DEF_GAP_W   = 4;

  localparam logic [3:0] PAT_1011 = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that saturates at zero.
//   clk, reset  - clock, synchronous active-high reset (clears count)
//   load        - load load_val (takes priority over dec)
//   load_val    - value to load
//   dec         - decrement by one when non-zero
//   count       - current value
//   zero        - count == 0
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB-first, with repeats and
// idle gaps between repetitions.
//   clk, reset      - clock, synchronous active-high reset
//   pat_data        - pattern, bit L-1 sent first
//   pat_len         - pattern length L (0 or >MAX_LEN means MAX_LEN)
//   pat_repeat      - extra repetitions R (R+1 emissions total)
//   pat_gap         - idle cycles G between repetitions
//   pat_valid       - request valid; pat_ready - request can be taken
//   out_bit         - serial data (0 when out_valid is low)
//   out_valid       - out_bit carries a pattern bit
//   busy            - any state but IDLE
//   done            - one-cycle pulse after the final bit
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [REP_W-1:0]   pat_repeat,
  input  logic [GAP_W-1:0]   pat_gap,
  input  logic               pat_valid,
  output logic               pat_ready,
  output logic               out_bit,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  seq_state_e state_r, state_s;

  logic [MAX_LEN-1:0] data_r;
  logic [LEN_W-1:0]   len_r;
  logic [GAP_W-1:0]   gap_r;

  logic [LEN_W-1:0]   clamped_len_s;
  logic               accept_s;

  logic               idx_load_s, idx_dec_s, idx_zero_s;
  logic [IDX_W-1:0]   idx_load_val_s, idx_cnt_s;
  logic               rep_load_s, rep_dec_s, rep_zero_s;
  logic [REP_W-1:0]   rep_cnt_s;
  logic               gap_load_s, gap_dec_s, gap_zero_s;
  logic [GAP_W-1:0]   gap_load_val_s, gap_cnt_s;

  assign accept_s = pat_valid && (state_r == ST_IDLE);

  // Length clamping: zero or oversize lengths mean a full-width pattern.
  always_comb begin
    clamped_len_s = pat_len;
    if ((pat_len == LEN_W'(0)) || (pat_len > LEN_W'(MAX_LEN))) begin
      clamped_len_s = LEN_W'(MAX_LEN);
    end else begin
      clamped_len_s = pat_len;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture: inputs are only looked at on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      len_r  <= '0;
      gap_r  <= '0;
    end else if (accept_s) begin
      data_r <= pat_data;
      len_r  <= clamped_len_s;
      gap_r  <= pat_gap;
    end else begin
      data_r <= data_r;
      len_r  <= len_r;
      gap_r  <= gap_r;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_s        = state_r;
    idx_load_s     = 1'b0;
    idx_load_val_s = IDX_W'(len_r - LEN_W'(1));
    idx_dec_s      = 1'b0;
    rep_load_s     = 1'b0;
    rep_dec_s      = 1'b0;
    gap_load_s     = 1'b0;
    gap_load_val_s = gap_r - GAP_W'(1);
    gap_dec_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pat_valid) begin
          state_s        = ST_SHIFT;
          idx_load_s     = 1'b1;
          idx_load_val_s = IDX_W'(clamped_len_s - LEN_W'(1));
          rep_load_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!idx_zero_s) begin
          idx_dec_s = 1'b1;
        end else if (rep_zero_s) begin
          state_s = ST_DONE;
        end else begin
          rep_dec_s = 1'b1;
          if (gap_r != GAP_W'(0)) begin
            state_s    = ST_GAP;
            gap_load_s = 1'b1;
          end else begin
            // Back-to-back emission: reload the index without a bubble.
            idx_load_s = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_zero_s) begin
          state_s    = ST_SHIFT;
          idx_load_s = 1'b1;
        end else begin
          gap_dec_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  seq_down_counter #(.W(IDX_W)) u_idx_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load_s),
    .load_val (idx_load_val_s),
    .dec      (idx_dec_s),
    .count    (idx_cnt_s),
    .zero     (idx_zero_s)
  );

  seq_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load_s),
    .load_val (pat_repeat),
    .dec      (rep_dec_s),
    .count    (rep_cnt_s),
    .zero     (rep_zero_s)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .load_val (gap_load_val_s),
    .dec      (gap_dec_s),
    .count    (gap_cnt_s),
    .zero     (gap_zero_s)
  );

  // Outputs are pure decodes of registered state and counters.
  assign pat_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign out_valid = (state_r == ST_SHIFT);
  assign out_bit   = out_valid & data_r[idx_cnt_s];

  logic unused_s;
  assign unused_s = ^{rep_cnt_s, gap_cnt_s};

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter and the driving end of the team's serial sequence-detection datapath. It accepts a parallel pattern of 1..MAX_LEN bits over a valid/ready handshake. It shifts the pattern out MSB-first, one bit per clock, optionally repeating it with idle gap cycles between repetitions. Its output feeds serial sequence detectors, such as the 1011 detector, in benches and in the datapath.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- REP_W, 4, width of the repeat-count field
- GAP_W, 4, width of the gap-length field
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high; clock clk
- pat_data  input  MAX_LEN  pattern; bit pat_len-1 is sent first, bit 0 last
- pat_len  input  $clog2(MAX_LEN+1)  pattern length; 0 or >MAX_LEN means MAX_LEN
- pat_repeat  input  REP_W  extra repetitions; total emissions = pat_repeat+1
- pat_gap  input  GAP_W  idle cycles inserted between repetitions (not after the last)
- pat_valid  input  1  request valid
- pat_ready  output  1  block can accept a request
- out_bit  output  1  serial data; 0 whenever out_valid=0
- out_valid  output  1  out_bit carries a pattern bit this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final bit of the final repetition

## Operation
- FSM states: IDLE, SHIFT, GAP, DONE.
- **IDLE**
  - pat_ready=1.
  - On pat_valid&&pat_ready, register pat_data, the clamped length L, the repeat count R and the gap G; go to SHIFT with bit index = L-1.
- **SHIFT**
  - out_valid=1; out_bit = data[bit index].
  - Bit index decrements each cycle.
  - At index 0:
    - if remaining repeats is 0, go to DONE;
    - else if G>0, go to GAP with gap counter = G-1, and decrement repeats;
    - else reload index = L-1, stay in SHIFT, and decrement repeats (back-to-back emissions, no bubble).
- **GAP**
  - out_valid=0, out_bit=0.
  - When the gap counter reaches 0, reload index = L-1 and go to SHIFT.
  - Otherwise decrement the gap counter.
- **DONE**
  - done=1, pat_ready=0.
  - Unconditionally go to IDLE.
- Inputs are sampled only at the accept edge; changes while busy are ignored.
- pat_valid while not ready has no effect. The requester holds the request until accepted.
- **Clamping:** pat_len=0 or >MAX_LEN uses L=MAX_LEN. L=1 is legal (single-bit emissions).
- **Reset** (any state, including mid-pattern):
  - next edge enters IDLE;
  - all counters and registers cleared;
  - no done pulse.
- **Reset values:** pat_ready=1 after reset is released; out_bit=0, out_valid=0, busy=0, done=0.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths; pat_ready depends only on state.
- **Accept at edge N:**
  - first bit is valid in cycle N+1;
  - last bit is valid in cycle N+T, where T = L·(R+1) + G·R;
  - done is high in cycle N+T+1;
  - pat_ready returns in cycle N+T+2.
- **Minimum request spacing:** T+2 cycles.
- Maximum T = MAX_LEN·2^REP_W + (2^GAP_W-1)·(2^REP_W-1). Counter widths must cover the full ranges: index $clog2(MAX_LEN), repeat REP_W, gap GAP_W.
- **Reset during SHIFT:** out_valid drops at the reset edge. The partially sent pattern is abandoned.

## Structure
- Shared package seq_pkg:
  - state enum (IDLE=0, SHIFT=1, GAP=2, DONE=3, 2-bit);
  - default MAX_LEN, REP_W and GAP_W constants;
  - the 1011 pattern constant, which is also used by the detector benches.
- One sub-module, seq_down_counter (parameter W; ports load, load_val, dec, zero). It is instantiated three times: bit index, repeat and gap.
- FSM and output muxing live in the top level.

## Test plan
- pat_data=8'b0000_1011, len=4, repeat=0, gap=0; accept at edge 0:
  - out_bit 1,0,1,1 with out_valid in cycles 1-4;
  - done in cycle 5;
  - pat_ready in cycle 6.
- Same pattern, repeat=2, gap=0: 12 consecutive valid bits 1011 1011 1011; done in cycle 13. Looped into the 1011 detector, seq_seen must assert after each emission.
- pat_data=8'b101, len=3, repeat=1, gap=3:
  - valid bits 1,0,1 in cycles 1-3;
  - out_valid=0 in cycles 4-6;
  - bits 1,0,1 in cycles 7-9;
  - done in cycle 10.
- pat_len=0 with pat_data=8'hA5: 8 bits 1,0,1,0,0,1,0,1 are emitted.
- reset asserted in cycle 2 of a 4-bit pattern:
  - out_valid=0 from the next cycle;
  - no done pulse;
  - pat_ready=1 once reset is released.
- pat_valid held high continuously: exactly one accept per T+2 cycles; pat_valid pulses while busy are ignored.
